coeff_bank_sched: RTL



---
 rtl/coeff_bank_sched_pkg.sv | 11 +
 rtl/coeff_bank_sched_if.sv | 32 +++
 rtl/coeff_bank_rd_seq.sv | 67 ++++++
 rtl/coeff_bank_sched.sv | 111 +++++++++++
 4 files changed

// File: rtl/coeff_bank_sched_pkg.sv
// Shared constants and state encodings for the STFT/ISTFT ping-pong coefficient store.
package coeff_bank_sched_pkg;
  localparam int N_COEFF = 180;
  localparam int COEFF_W = 28;
  localparam int AW      = 8;

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_COEFF - 1);

  typedef enum logic { ST_INIT = 1'b0, ST_RUN  = 1'b1 } top_state_e;
  typedef enum logic { R_IDLE  = 1'b0, R_DRAIN = 1'b1 } rd_state_e;
endpackage

// File: rtl/coeff_bank_sched_if.sv
// Writer/reader handshake and bank RAM control bundle of the coefficient scheduler.
interface coeff_bank_sched_if;
  import coeff_bank_sched_pkg::*;

  logic          wr_valid;
  logic          wr_ready;
  logic          wr_en;
  logic          wr_zero;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          rd_req;
  logic          rd_stall;
  logic          rd_start;
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic          rd_last;
  logic          init_done;
  logic          overrun;

  modport master (
    input  wr_valid, rd_req, rd_stall,
    output wr_ready, wr_en, wr_zero, wr_bank, wr_addr,
           rd_start, rd_en, rd_bank, rd_addr, rd_last, init_done, overrun
  );

  modport slave (
    output wr_valid, rd_req, rd_stall,
    input  wr_ready, wr_en, wr_zero, wr_bank, wr_addr,
           rd_start, rd_en, rd_bank, rd_addr, rd_last, init_done, overrun
  );
endinterface

// File: rtl/coeff_bank_rd_seq.sv
// Read sequencer: drains one full bank per frame toward the ISTFT, alternating banks.
module coeff_bank_rd_seq
  import coeff_bank_sched_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run_i,
  input  logic [1:0]    bank_full_i,
  input  logic          rd_req_i,
  input  logic          rd_stall_i,
  output logic          rd_start_o,
  output logic          rd_en_o,
  output logic          rd_bank_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          rd_last_o
);
  rd_state_e     state_q, state_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          rd_sel_q, rd_sel_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= R_IDLE;
      rd_cnt_q <= '0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  // The start cycle issues no read, which guarantees an idle gap between frames.
  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_sel_d   = rd_sel_q;
    rd_start_o = 1'b0;
    rd_en_o    = 1'b0;
    rd_last_o  = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (run_i && bank_full_i[rd_sel_q] && rd_req_i) begin
          rd_start_o = 1'b1;
          rd_cnt_d   = '0;
          state_d    = R_DRAIN;
        end
      end
      R_DRAIN: begin
        rd_en_o = ~rd_stall_i;
        if (rd_en_o) begin
          if (rd_cnt_q == LAST_ADDR) begin
            rd_last_o = 1'b1;
            rd_cnt_d  = '0;
            rd_sel_d  = ~rd_sel_q;
            state_d   = R_IDLE;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  assign rd_bank_o = rd_sel_q;
  assign rd_addr_o = rd_cnt_q;
endmodule

// File: rtl/coeff_bank_sched.sv
// Ping-pong coefficient bank scheduler: zero-fills both banks, then arbitrates STFT writes and ISTFT drains.
module coeff_bank_sched
  import coeff_bank_sched_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  coeff_bank_sched_if.master bus
);
  top_state_e    state_q, state_d;
  logic [AW-1:0] init_addr_q, init_addr_d;
  logic          init_bank_q, init_bank_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_sel_q, wr_sel_d;
  logic [1:0]    bank_full_q, bank_full_d;
  logic          overrun_q, overrun_d;

  logic          wr_ready, wr_en, wr_zero, wr_bank;
  logic [AW-1:0] wr_addr;
  logic          rd_bank, rd_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      init_bank_q <= 1'b0;
      wr_cnt_q    <= '0;
      wr_sel_q    <= 1'b0;
      bank_full_q <= 2'b00;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_bank_q <= init_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_sel_q    <= wr_sel_d;
      bank_full_q <= bank_full_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_bank_d = init_bank_q;
    wr_cnt_d    = wr_cnt_q;
    wr_sel_d    = wr_sel_q;
    bank_full_d = bank_full_q;
    overrun_d   = overrun_q;
    wr_ready    = 1'b0;
    wr_en       = 1'b0;
    wr_zero     = 1'b0;
    wr_bank     = init_bank_q;
    wr_addr     = init_addr_q;
    case (state_q)
      ST_INIT: begin
        // Gated by rst_n so the zero-fill strobe stays low while reset is held.
        wr_en   = rst_n;
        wr_zero = rst_n;
        if (init_addr_q == LAST_ADDR) begin
          init_addr_d = '0;
          init_bank_d = 1'b1;
          if (init_bank_q) state_d = ST_RUN;
        end else begin
          init_addr_d = init_addr_q + 1'b1;
        end
      end
      ST_RUN: begin
        wr_ready = ~bank_full_q[wr_sel_q];
        wr_en    = bus.wr_valid & wr_ready;
        wr_bank  = wr_sel_q;
        wr_addr  = wr_cnt_q;
        if (wr_en) begin
          if (wr_cnt_q == LAST_ADDR) begin
            wr_cnt_d              = '0;
            bank_full_d[wr_sel_q] = 1'b1;
            wr_sel_d              = ~wr_sel_q;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
        if (bus.wr_valid && !wr_ready) overrun_d = 1'b1;
        // Write and read completions in one cycle always hit different banks.
        if (rd_last) bank_full_d[rd_bank] = 1'b0;
      end
    endcase
  end

  coeff_bank_rd_seq u_rd_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (state_q == ST_RUN),
    .bank_full_i (bank_full_q),
    .rd_req_i    (bus.rd_req),
    .rd_stall_i  (bus.rd_stall),
    .rd_start_o  (bus.rd_start),
    .rd_en_o     (bus.rd_en),
    .rd_bank_o   (rd_bank),
    .rd_addr_o   (bus.rd_addr),
    .rd_last_o   (rd_last)
  );

  assign bus.wr_ready  = wr_ready;
  assign bus.wr_en     = wr_en;
  assign bus.wr_zero   = wr_zero;
  assign bus.wr_bank   = wr_bank;
  assign bus.wr_addr   = wr_addr;
  assign bus.rd_bank   = rd_bank;
  assign bus.rd_last   = rd_last;
  assign bus.init_done = (state_q == ST_RUN);
  assign bus.overrun   = overrun_q;
endmodule
